pwm_capture: RTL and testbench

Measures an incoming PWM waveform, which is the receive-side counterpart of the PWM generator. It reports the high time and the period of each complete cycle, counted in clk cycles.
The input is asynchronous. It is synchronized, edge-detected, and timed by a small FSM, and a result is published once per rising edge.
It sits beside the generator in the tile so that generated waveforms can be looped back and checked on-chip.

---
 rtl/pwm_capture.sv | 195 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an asynchronous PWM input and measures high time and period in clk cycles.
// Optional 3-sample glitch filter on the synchronized input: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] high_cnt,
   output logic [WIDTH-1:0] period_cnt,
   output logic             valid,
   output logic             timeout,
   output logic             level
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic lvl_cur, lvl_prev;
   logic rise, fall;

   always_comb begin
      sync1_d = pwm_in;
      sync2_d = sync1_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic hist1_q, hist1_d;
   logic hist2_q, hist2_d;
   logic filt_q, filt_d;

   // The filtered level only moves once three consecutive synchronized samples agree.
   always_comb begin
      hist1_d = sync2_q;
      hist2_d = hist1_q;
      filt_d  = filt_q;
      if ((sync2_q == hist1_q) && (sync2_q == hist2_q)) begin
         filt_d = sync2_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist1_q <= 1'b0;
         hist2_q <= 1'b0;
         filt_q  <= 1'b0;
      end else begin
         hist1_q <= hist1_d;
         hist2_q <= hist2_d;
         filt_q  <= filt_d;
      end
   end

   assign lvl_cur  = filt_d;
   assign lvl_prev = filt_q;
   assign level    = filt_q;
`else
   logic sync2_dly_q, sync2_dly_d;

   always_comb begin
      sync2_dly_d = sync2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync2_dly_q <= 1'b0;
      end else begin
         sync2_dly_q <= sync2_dly_d;
      end
   end

   assign lvl_cur  = sync2_q;
   assign lvl_prev = sync2_dly_q;
   assign level    = sync2_q;
`endif

   assign rise = lvl_cur & ~lvl_prev;
   assign fall = ~lvl_cur & lvl_prev;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] high_lat_q, high_lat_d;
   logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
   logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   // NOTE: every signal gets a default before the case so no latch can be inferred.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      high_lat_d   = high_lat_q;
      high_cnt_d   = high_cnt_q;
      period_cnt_d = period_cnt_q;
      valid_d      = 1'b0;
      timeout_d    = timeout_q;

      if (!en) begin
         state_d   = IDLE;
         cnt_d     = '0;
         timeout_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (rise) begin
                  state_d = HIGH;
                  cnt_d   = CNT_ONE;
               end
            end
            HIGH: begin
               cnt_d = cnt_inc;
               if (fall) begin
                  high_lat_d = cnt_q;
                  state_d    = LOW;
               end else if (cnt_q == CNT_MAX) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  timeout_d = 1'b1;
               end
            end
            LOW: begin
               // A rise on the terminal count still closes the period rather than timing out.
               if (rise) begin
                  period_cnt_d = cnt_q;
                  high_cnt_d   = high_lat_q;
                  valid_d      = 1'b1;
                  timeout_d    = 1'b0;
                  cnt_d        = CNT_ONE;
                  state_d      = HIGH;
               end else if (cnt_q == CNT_MAX) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         high_lat_q   <= '0;
         high_cnt_q   <= '0;
         period_cnt_q <= '0;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         high_lat_q   <= high_lat_d;
         high_cnt_q   <= high_cnt_d;
         period_cnt_q <= period_cnt_d;
         valid_q      <= valid_d;
         timeout_q    <= timeout_d;
      end
   end

   assign high_cnt   = high_cnt_q;
   assign period_cnt = period_cnt_q;
   assign valid      = valid_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (WIDTH=8): duty measurement, duty change, enable drop,
// timeout, asynchronous reset and glitch behaviour, all with hand-computed expectations.
module tb_pwm_capture;

   localparam int WIDTH = 8;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int LAT  = 5;
   localparam int LOW2 = 3;
`else
   localparam int LAT  = 3;
   localparam int LOW2 = 2;
`endif

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             pwm_in;
   logic [WIDTH-1:0] high_cnt;
   logic [WIDTH-1:0] period_cnt;
   logic             valid;
   logic             timeout;
   logic             level;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_valid  = 0;
   int last_high   = 0;
   int last_period = 0;
   int last_vcyc   = 0;

   pwm_capture #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .pwm_in     (pwm_in),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .valid      (valid),
      .timeout    (timeout),
      .level      (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Records every valid strobe together with the cycle it appeared on.
   always @(posedge clk) begin
      #1;
      if (rst_n && valid) begin
         n_valid     = n_valid + 1;
         last_high   = int'(high_cnt);
         last_period = int'(period_cnt);
         last_vcyc   = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic run(input logic p, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = p;
         @(negedge clk);
      end
   endtask

   // One h-high/l-low period starting at its rise; the rise closes the previous period,
   // whose expected result (if any) is eh/ep.
   task automatic period(input int h, input int l, input bit exp_v, input int eh, input int ep);
      int v0;
      int rc;
      v0 = n_valid;
      rc = cyc;
      run(1'b1, h);
      run(1'b0, l);
      check("valid_count", n_valid - v0, exp_v ? 1 : 0);
      if (exp_v) begin
         check("high_cnt", last_high, eh);
         check("period_cnt", last_period, ep);
         check("valid_latency", last_vcyc - rc, LAT);
      end
   endtask

   initial begin
      int v0;
      int rc;

      rst_n  = 1'b0;
      en     = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_high_cnt", high_cnt, 0);
      check("rst_period_cnt", period_cnt, 0);
      check("rst_valid", valid, 0);
      check("rst_timeout", timeout, 0);
      check("rst_level", level, 0);
      rst_n = 1'b1;
      run(1'b0, 5);

      // 3 high / 7 low: first rise gives nothing, then 3/10 each period.
      period(3, 7, 1'b0, 0, 0);
      period(3, 7, 1'b1, 3, 10);
      period(3, 7, 1'b1, 3, 10);
      period(3, 7, 1'b1, 3, 10);
      check("level_low", level, 0);

      // Duty change to 8 high: transitional 8/15, then steady.
      period(8, 7, 1'b1, 3, 10);
      period(8, LOW2, 1'b1, 8, 15);
      period(8, LOW2, 1'b1, 8, 8 + LOW2);
      period(8, LOW2, 1'b1, 8, 8 + LOW2);

      // Enable dropped mid-period.
      v0 = n_valid;
      rc = cyc;
      run(1'b1, 6);
      check("pre_en_valid_count", n_valid - v0, 1);
      check("pre_en_period", last_period, 8 + LOW2);
      check("pre_en_latency", last_vcyc - rc, LAT);
      v0 = n_valid;
      en = 1'b0;
      run(1'b0, 5);
      check("en_off_valid_count", n_valid - v0, 0);
      check("en_off_high_hold", high_cnt, 8);
      check("en_off_period_hold", period_cnt, 8 + LOW2);
      check("en_off_timeout", timeout, 0);
      en = 1'b1;
      run(1'b0, 3);
      period(3, 7, 1'b0, 0, 0);
      period(3, 7, 1'b1, 3, 10);

      // Timeout: hold the input high past the terminal count.
      v0 = n_valid;
      rc = cyc;
      run(1'b1, LAT + 254);
      check("timeout_before_terminal", timeout, 0);
      run(1'b1, 1);
      check("timeout_set", timeout, 1);
      check("timeout_valid_count", n_valid - v0, 1);
      check("timeout_high_hold", high_cnt, 3);
      check("timeout_period_hold", period_cnt, 10);
      run(1'b1, 5);
      run(1'b0, 4);
      period(4, 4, 1'b0, 0, 0);
      check("timeout_sticky", timeout, 1);
      period(4, 4, 1'b1, 4, 8);
      check("timeout_cleared", timeout, 0);

      // Asynchronous reset in the middle of a high phase.
      run(1'b1, 5);
      check("pre_rst_high_cnt", high_cnt, 4);
      check("pre_rst_level", level, 1);
      #2;
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      #1;
      check("async_rst_high_cnt", high_cnt, 0);
      check("async_rst_period_cnt", period_cnt, 0);
      check("async_rst_level", level, 0);
      check("async_rst_timeout", timeout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(1'b0, 5);
      period(3, 7, 1'b0, 0, 0);
      period(3, 7, 1'b1, 3, 10);

      // 2-cycle glitch inside the low phase.
      v0 = n_valid;
      run(1'b1, 3);
      run(1'b0, 3);
      run(1'b1, 2);
      run(1'b0, 2);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      check("glitch_valid_count", n_valid - v0, 1);
      check("glitch_prev_period", last_period, 10);
      period(3, 7, 1'b1, 3, 10);
`else
      check("glitch_valid_count", n_valid - v0, 2);
      check("glitch_high", last_high, 3);
      check("glitch_period", last_period, 6);
      period(3, 7, 1'b1, 2, 4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
